seq_divider: RTL and testbench

Multi-cycle signed integer divider for the arithmetic datapath. It is the inverse companion of the pipelined multiplier and reuses the same ripple-subtract style: one restoring subtract per cycle, sign-magnitude pre/post processing. Operands enter through a valid/ready handshake. Quotient, remainder and status leave through a second valid/ready handshake and are held under backpressure.

---
 rtl/seqdiv_pkg.sv | 16 +
 rtl/seq_divider_restore_step.sv | 35 +++
 rtl/seq_divider.sv | 155 +++++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seqdiv_pkg.sv
// seqdiv_pkg: shared state encoding, default width and saturation helpers for seq_divider.
package seqdiv_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/seq_divider_restore_step.sv
// restore_step: one restoring division step built as a ripple subtract whose borrow-out selects restore.
module restore_step
    import seqdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] x;
    logic [WIDTH+1:0] y;
    logic [WIDTH:0]   diff;
    logic             borrow;

    assign x = {rem_i, bit_i};
    assign y = {2'b00, div_i};

    always_comb begin
        diff   = '0;
        borrow = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = x[i] ^ y[i] ^ borrow;
            borrow  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow);
        end
        borrow = (~x[WIDTH+1] & y[WIDTH+1]) | (~(x[WIDTH+1] ^ y[WIDTH+1]) & borrow);
    end

    assign q_o   = ~borrow;
    assign rem_o = borrow ? x[WIDTH:0] : diff;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider with valid/ready in and out.
// Define SEQDIV_STATUS_EN to add the div_by_zero and overflow status outputs.
module seq_divider
    import seqdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SEQDIV_STATUS_EN
    output logic             div_by_zero,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH:0]   part_q, part_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQDIV_STATUS_EN
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    // The most negative operand negates to itself, which is exactly 2^(WIDTH-1) unsigned.
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;

    restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (part_q),
        .div_i (den_q),
        .bit_i (num_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        den_d   = den_q;
        part_d  = part_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef SEQDIV_STATUS_EN
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                num_d  = dvd_mag;
                den_d  = dvs_mag;
                part_d = '0;
                cnt_d  = '0;
                sq_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                sr_d   = dividend[WIDTH-1];
                if (divisor == '0) begin
                    state_d = DONE;
                    quo_d   = dividend[WIDTH-1] ? SAT_N : SAT_P;
                    rem_d   = dividend;
`ifdef SEQDIV_STATUS_EN
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = ITER;
                end
            end
            // The dividend register shifts out its MSB while quotient bits shift in at the LSB.
            ITER: begin
                part_d = step_rem;
                num_d  = {num_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                quo_d   = sq_q ? -num_q : num_q;
                rem_d   = sr_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
`ifdef SEQDIV_STATUS_EN
                dbz_d   = 1'b0;
                ovf_d   = (num_q == SAT_N) && !sq_q;
`endif
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            part_q  <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef SEQDIV_STATUS_EN
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            den_q   <= den_d;
            part_q  <= part_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef SEQDIV_STATUS_EN
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef SEQDIV_STATUS_EN
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider using an integer reference model.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SEQDIV_STATUS_EN
    logic         div_by_zero;
    logic         overflow;
`endif

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef SEQDIV_STATUS_EN
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
`endif
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           edges;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input int a, input int b);
        exp_t                e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sd;
        int                  ai;
        int                  bi;
        int                  t;
        sa = W'(a);
        sd = W'(b);
        ai = sa;
        bi = sd;
        if (bi == 0) begin
            e.q     = (ai < 0) ? W'(32'h8000) : W'(32'h7fff);
            e.r     = sa;
            e.dz    = 1'b1;
            e.ov    = 1'b0;
            e.edges = 0;
        end else begin
            e.q     = W'(ai / bi);
            e.r     = W'(ai % bi);
            e.dz    = 1'b0;
            e.ov    = (ai == -32768) && (bi == -1);
            e.edges = W + 1;
        end
        sb.push_back(e);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 50) check("accept_timeout", 32'(t), 32'd0);
        dividend = sa;
        divisor  = sd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_one();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        last = sb.pop_front();
        check("latency", 32'(n), 32'(last.edges));
        check("quotient", 32'(quotient), 32'(last.q));
        check("remainder", 32'(remainder), 32'(last.r));
`ifdef SEQDIV_STATUS_EN
        check("div_by_zero", 32'(div_by_zero), 32'(last.dz));
        check("overflow", 32'(overflow), 32'(last.ov));
`endif
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("release_idle", 32'(in_ready), 32'd1);
        end
    endtask

    int da[10] = '{100, -100, 100, -100, -32768, -32768, 5, -5, 0, 32767};
    int db[10] = '{7, 7, -7, -7, -1, 1, 0, 0, 3, -1};

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            start(da[i], db[i]);
            finish_one();
        end
        for (int i = 0; i < 20; i++) begin
            start(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 511)) - 256);
            finish_one();
        end
        out_ready = 1'b0;
        start(1234, -17);
        finish_one();
        for (int i = 0; i < 10; i++) begin
            dividend = 16'd7;
            divisor  = 16'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_quotient", 32'(quotient), 32'(last.q));
            check("bp_remainder", 32'(remainder), 32'(last.r));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        start(-7, 2);
        finish_one();
        start(1000, 3);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(9, 3);
        finish_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
